diff_arbiter: RTL and testbench

Sequencing and arbitration controller for the shared 16-bit nibble-equality comparator (`diff`). Two requesters submit operand pairs. The block grants one at a time by round-robin and drives the registered operands into the single comparator instance. It waits a programmable number of cycles for the gate-delayed result to settle, then captures it. The captured flags are returned with an equality summary over a valid/ack handshake.

---
 rtl/diff_arbiter.sv | 137 +++++++++++++
 tb/tb_diff_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/diff_arbiter.sv
// diff_arbiter: round-robin sequencer for a shared 16-bit nibble-equality comparator.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req0_i, a0_i, b0_i       requester 0 request and operands
//   req1_i, a1_i, b1_i       requester 1 request and operands
//   cmp_a_o, cmp_b_o         registered operands driven into the comparator
//   cmp_d_i                  comparator result, bit i = nibble i equal
//   gnt_o                    one-cycle one-hot grant pulse
//   busy_o                   high outside IDLE
//   rsp_valid_o, rsp_ack_i   response handshake
//   rsp_id_o, rsp_d_o        owner of the response and captured comparator flags
//   rsp_eq_o, rsp_ndiff_o    all-equal summary and count of unequal nibbles
module diff_arbiter #(
    parameter int unsigned SETTLE = 4  // settle cycles, legal range 1..15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req0_i,
    input  logic [15:0] a0_i,
    input  logic [15:0] b0_i,
    input  logic        req1_i,
    input  logic [15:0] a1_i,
    input  logic [15:0] b1_i,
    output logic [15:0] cmp_a_o,
    output logic [15:0] cmp_b_o,
    input  logic [3:0]  cmp_d_i,
    output logic [1:0]  gnt_o,
    output logic        busy_o,
    output logic        rsp_valid_o,
    output logic        rsp_id_o,
    output logic [3:0]  rsp_d_o,
    output logic        rsp_eq_o,
    output logic [2:0]  rsp_ndiff_o,
    input  logic        rsp_ack_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RESP} state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        valid_q, valid_d, id_q, id_d, eq_q, eq_d;
    logic [3:0]  rsp_d_q, rsp_d_d;
    logic [2:0]  ndiff_q, ndiff_d, ndiff;
    logic        pick1;

    // last_q remembers the previously granted requester; on a tie the other one wins
    assign pick1 = req1_i && (!req0_i || !last_q);
    assign ndiff = 3'd4 - ({2'b0, cmp_d_i[0]} + {2'b0, cmp_d_i[1]}
                         + {2'b0, cmp_d_i[2]} + {2'b0, cmp_d_i[3]});

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        cmp_a_d = cmp_a_q;
        cmp_b_d = cmp_b_q;
        gnt_d   = 2'b00;
        valid_d = valid_q;
        id_d    = id_q;
        rsp_d_d = rsp_d_q;
        eq_d    = eq_q;
        ndiff_d = ndiff_q;
        case (state_q)
            ST_IDLE: begin
                if (req0_i || req1_i) begin
                    gnt_d   = pick1 ? 2'b10 : 2'b01;
                    cmp_a_d = pick1 ? a1_i : a0_i;
                    cmp_b_d = pick1 ? b1_i : b0_i;
                    id_d    = pick1;
                    last_d  = pick1;
                    cnt_d   = 4'(SETTLE - 1);
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    rsp_d_d = cmp_d_i;
                    eq_d    = &cmp_d_i;
                    ndiff_d = ndiff;
                    valid_d = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ack_i) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            cmp_a_q <= '0;
            cmp_b_q <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= 1'b0;
            rsp_d_q <= '0;
            eq_q    <= 1'b0;
            ndiff_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            cmp_a_q <= cmp_a_d;
            cmp_b_q <= cmp_b_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            rsp_d_q <= rsp_d_d;
            eq_q    <= eq_d;
            ndiff_q <= ndiff_d;
        end
    end

    assign cmp_a_o     = cmp_a_q;
    assign cmp_b_o     = cmp_b_q;
    assign gnt_o       = gnt_q;
    assign busy_o      = state_q != ST_IDLE;
    assign rsp_valid_o = valid_q;
    assign rsp_id_o    = id_q;
    assign rsp_d_o     = rsp_d_q;
    assign rsp_eq_o    = eq_q;
    assign rsp_ndiff_o = ndiff_q;

endmodule

// File: tb/tb_diff_arbiter.sv
// tb_diff_arbiter: self-checking bench for diff_arbiter with a delayed comparator stand-in.
`timescale 1ns/100ps
module tb_diff_arbiter;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, rsp_ack;
    logic [15:0] a0, b0, a1, b1;
    logic [15:0] cmp_a, cmp_b;
    logic [3:0]  cmp_d;
    logic [1:0]  gnt;
    logic        busy, rsp_valid, rsp_id, rsp_eq;
    logic [3:0]  rsp_d;
    logic [2:0]  rsp_ndiff;

    int tests = 0;
    int fails = 0;

    always #12.5 clk = ~clk;

    diff_arbiter #(.SETTLE(S)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_i(req0), .a0_i(a0), .b0_i(b0),
        .req1_i(req1), .a1_i(a1), .b1_i(b1),
        .cmp_a_o(cmp_a), .cmp_b_o(cmp_b), .cmp_d_i(cmp_d),
        .gnt_o(gnt), .busy_o(busy),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_d_o(rsp_d),
        .rsp_eq_o(rsp_eq), .rsp_ndiff_o(rsp_ndiff), .rsp_ack_i(rsp_ack)
    );

    // Comparator stand-in: result settles 80 ns after the operands change, so an
    // early capture would pick up the previous operands' flags.
    function automatic logic [3:0] nib_eq(input logic [15:0] x, input logic [15:0] y);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ((x >> (4 * i)) & 16'hF) == ((y >> (4 * i)) & 16'hF);
        return r;
    endfunction

    assign #80 cmp_d = nib_eq(cmp_a, cmp_b);

    function automatic int ref_ndiff(input logic [15:0] x, input logic [15:0] y);
        int n = 0;
        for (int i = 0; i < 4; i++) if (((x >> (4 * i)) & 16'hF) != ((y >> (4 * i)) & 16'hF)) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One single-requester transaction, response held for 'hold' cycles before ack.
    task automatic txn(input logic id, input logic [15:0] a, input logic [15:0] b, input int hold);
        int cyc;
        logic [3:0] ed;
        ed = nib_eq(a, b);
        if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
        else    begin req0 = 1'b1; a0 = a; b0 = b; end
        cyc = 0;
        while (gnt == 2'b00 && cyc < 20) begin step(); cyc++; end
        check("gnt", 32'(gnt), id ? 32'd2 : 32'd1);
        check("cmp_a", 32'(cmp_a), 32'(a));
        check("cmp_b", 32'(cmp_b), 32'(b));
        check("busy_grant", 32'(busy), 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            step();
            cyc++;
            if (cyc == 1) check("gnt_pulse", 32'(gnt), 32'd0);
        end
        check("latency", 32'(cyc), 32'(S));
        check("rsp_d", 32'(rsp_d), 32'(ed));
        check("rsp_eq", 32'(rsp_eq), 32'(ed == 4'hF));
        check("rsp_ndiff", 32'(rsp_ndiff), 32'(ref_ndiff(a, b)));
        check("rsp_id", 32'(rsp_id), 32'(id));
        repeat (hold) begin
            step();
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_d", 32'(rsp_d), 32'(ed));
        end
        rsp_ack = 1'b1;
        step();
        rsp_ack = 1'b0;
        check("ack_valid", 32'(rsp_valid), 32'd0);
        check("ack_busy", 32'(busy), 32'd0);
        check("ack_keep_d", 32'(rsp_d), 32'(ed));
    endtask

    initial begin
        int cyc, ng, both;
        int gid[4];
        int gtime[4];
        logic [15:0] ra, rm;
        logic [3:0] ed;
        rst_n = 1'b0;
        {req0, req1, rsp_ack} = 3'b000;
        {a0, b0, a1, b1} = '0;
        step();
        step();
        check("reset_out", 32'({gnt, busy, rsp_valid, rsp_d, cmp_a}), 32'd0);
        rst_n = 1'b1;
        step();

        txn(1'b0, 16'h1234, 16'h1234, 0);
        txn(1'b1, 16'hABCD, 16'hAB0D, 0);
        txn(1'b0, 16'h0000, 16'hFFFF, 1);

        for (int k = 0; k < 8; k++) begin
            ra = 16'($urandom);
            rm = '0;
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 1) == 1) rm[4*i +: 4] = 4'($urandom_range(1, 15));
            txn(1'($urandom_range(0, 1)), ra, ra ^ rm, $urandom_range(0, 3));
        end

        // Backpressure with req1 pending behind a requester-0 response
        req0 = 1'b1; a0 = 16'h5A5A; b0 = 16'h5A0A;
        cyc = 0;
        while (gnt == 2'b00 && cyc < 20) begin step(); cyc++; end
        check("bp_gnt0", 32'(gnt), 32'd1);
        req0 = 1'b0;
        req1 = 1'b1; a1 = 16'hC3C3; b1 = 16'hC3C3;
        ed = nib_eq(16'h5A5A, 16'h5A0A);
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin step(); cyc++; end
        check("bp_valid", 32'(rsp_valid), 32'd1);
        for (int k = 0; k < 10; k++) begin
            step();
            check("bp_nogrant", 32'(gnt), 32'd0);
            check("bp_stable", 32'({rsp_valid, rsp_id, rsp_d, rsp_eq, rsp_ndiff}),
                  32'({1'b1, 1'b0, ed, 1'b0, 3'd1}));
        end
        rsp_ack = 1'b1;
        step();
        rsp_ack = 1'b0;
        check("bp_ack_valid", 32'(rsp_valid), 32'd0);
        check("bp_ack_nogrant", 32'(gnt), 32'd0);
        step();
        check("bp_gnt1", 32'(gnt), 32'd2);
        check("bp_cmp_a", 32'(cmp_a), 32'hC3C3);
        req1 = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin step(); cyc++; end
        check("bp_rsp1_eq", 32'(rsp_eq), 32'd1);
        rsp_ack = 1'b1;
        step();

        // Round-robin from reset with both requests held and ack tied high
        rst_n = 1'b0;
        step();
        req0 = 1'b1; a0 = 16'h1357; b0 = 16'h1350;
        req1 = 1'b1; a1 = 16'h2468; b1 = 16'h2468;
        rst_n = 1'b1;
        ng = 0; cyc = 0; both = 0;
        gid = '{-1, -1, -1, -1};
        gtime = '{0, 0, 0, 0};
        while (ng < 4 && cyc < 100) begin
            step();
            cyc++;
            if (gnt == 2'b11) both = 1;
            if (gnt != 2'b00) begin gid[ng] = 32'(gnt[1]); gtime[ng] = cyc; ng++; end
        end
        check("rr_count", 32'(ng), 32'd4);
        check("rr_first_time", 32'(gtime[0]), 32'd1);
        check("rr_both", 32'(both), 32'd0);
        for (int k = 0; k < 4; k++) check("rr_order", 32'(gid[k]), 32'(k % 2));
        for (int k = 1; k < 4; k++) check("rr_spacing", 32'(gtime[k] - gtime[k-1]), 32'(S + 2));

        // Reset two cycles into a requester-1 SETTLE, both requests still held
        step();
        step();
        #3 rst_n = 1'b0;
        #1;
        check("rst_ctrl", 32'({gnt, busy, rsp_valid, rsp_id, rsp_eq}), 32'd0);
        check("rst_rsp", 32'({rsp_d, rsp_ndiff}), 32'd0);
        check("rst_cmp", 32'({cmp_a, cmp_b}), 32'd0);
        @(negedge clk);
        step();
        check("rst_novalid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_regrant", 32'(gnt), 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
